// File: rtl/gray_px_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_px_arbiter_pkg                                             |
// | Purpose  : Shared pixel widths, arbiter state encoding and the RGB-to-gray |
// |            weighting used by gray_scale_core.                              |
// | Contents : MAX_PIXEL_BITS, PIXEL_WIDTH_OUT, arb_state_t + ST_* states,     |
// |            rgb_to_gray()                                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gray_px_arbiter_pkg;

  localparam int MAX_PIXEL_BITS  = 24;  // packed {R[23:16],G[15:8],B[7:0]}
  localparam int PIXEL_WIDTH_OUT = 8;

  // Arbiter FSM encoding.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_BURST0 = 2'd1;
  localparam arb_state_t ST_BURST1 = 2'd2;

  // Luma weights in 1/256 units. They sum to 235 so full white maps to 234,
  // keeping the product inside 16 bits.
  localparam logic [15:0] c_W_R = 16'd71;
  localparam logic [15:0] c_W_G = 16'd141;
  localparam logic [15:0] c_W_B = 16'd23;

  function automatic logic [PIXEL_WIDTH_OUT-1:0] rgb_to_gray(
    input logic [MAX_PIXEL_BITS-1:0] px
  );
    logic [15:0] acc;
    acc = 16'(px[23:16]) * c_W_R
        + 16'(px[15:8])  * c_W_G
        + 16'(px[7:0])   * c_W_B;
    return acc[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_out_fifo                                                   |
// | Purpose  : Synchronous FIFO with occupancy count. Push while full and pop  |
// |            while empty are ignored; push+pop in one cycle keeps the count. |
// | Ports    : clk, i_nreset (sync, active-low), i_push / i_data, i_pop,       |
// |            o_valid / o_data (head), o_count                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gray_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_nreset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int                c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != c_FULL);
  assign w_do_pop  = i_pop  && (r_count != '0);

  // Storage is not reset; o_valid qualifies the head.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/gray_scale_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_scale_core                                                 |
// | Purpose  : Converts one RGB pixel to gray with a fixed 1-cycle latency.    |
// |            No backpressure: every px_rdy_i pulse yields a px_rdy_o pulse.  |
// | Ports    : clk_i, nreset_i (sync, active-low), px_rdy_i / px_i (input     |
// |            strobe + pixel), px_rdy_o / px_gray_o (result strobe + gray)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gray_scale_core
  import gray_px_arbiter_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       px_rdy_i,
  input  logic [MAX_PIXEL_BITS-1:0]  px_i,
  output logic                       px_rdy_o,
  output logic [PIXEL_WIDTH_OUT-1:0] px_gray_o
);

  logic                       r_rdy;
  logic [PIXEL_WIDTH_OUT-1:0] r_gray;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      r_rdy  <= 1'b0;
      r_gray <= '0;
    end else begin
      r_rdy <= px_rdy_i;
      if (px_rdy_i) begin
        r_gray <= rgb_to_gray(px_i);
      end
    end
  end

  assign px_rdy_o  = r_rdy;
  assign px_gray_o = r_gray;

endmodule
`default_nettype wire

// File: rtl/gray_px_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_px_arbiter                                                 |
// | Purpose  : Burst arbiter sharing one gray_scale_core between two RGB       |
// |            sources; results are queued with their source tag in a FIFO.    |
// | Ports    : clk_i, nreset_i (sync, active-low)                              |
// |            srcN_valid_i / srcN_px_i / srcN_ready_o  - source handshakes    |
// |            out_valid_o / out_px_gray_o / out_src_o / out_ready_i - output  |
// |            busy_o - FSM active, pixel in the core, or FIFO non-empty       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gray_px_arbiter
  import gray_px_arbiter_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       src0_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0]  src0_px_i,
  output logic                       src0_ready_o,
  input  logic                       src1_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0]  src1_px_i,
  output logic                       src1_ready_o,
  output logic                       out_valid_o,
  output logic [PIXEL_WIDTH_OUT-1:0] out_px_gray_o,
  output logic                       out_src_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int                    c_CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int                    c_FCNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'(BURST_LEN - 1);
  localparam logic [c_FCNT_W-1:0]   c_DEPTH     = c_FCNT_W'(FIFO_DEPTH);

  arb_state_t                 r_state;
  logic [c_CNT_W-1:0]         r_beat;
  logic                       r_last_grant;  // 0: src0 granted last, 1: src1
  logic                       r_tag;         // source of the pixel inside the core

  logic                       w_core_rdy;
  logic [PIXEL_WIDTH_OUT-1:0] w_core_gray;
  logic [c_FCNT_W-1:0]        w_fifo_count;
  logic                       w_fifo_valid;
  logic [PIXEL_WIDTH_OUT:0]   w_fifo_head;
  logic                       w_room;
  logic                       w_ready0;
  logic                       w_ready1;
  logic                       w_acc0;
  logic                       w_acc1;
  logic                       w_accept;
  logic [MAX_PIXEL_BITS-1:0]  w_px;

  // Room is reserved for the pixel still inside the core, so the FIFO can
  // never be pushed while full. Ready does not look at out_ready_i.
  assign w_room   = (w_fifo_count + c_FCNT_W'(w_core_rdy)) < c_DEPTH;
  assign w_ready0 = nreset_i && (r_state == ST_BURST0) && w_room;
  assign w_ready1 = nreset_i && (r_state == ST_BURST1) && w_room;
  assign w_acc0   = w_ready0 && src0_valid_i;
  assign w_acc1   = w_ready1 && src1_valid_i;
  assign w_accept = w_acc0 || w_acc1;
  assign w_px     = w_acc1 ? src1_px_i : src0_px_i;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_last_grant <= 1'b1;   // first grant after reset goes to src0
      r_tag        <= 1'b0;
    end else begin
      r_tag <= w_acc1;
      case (r_state)
        ST_IDLE: begin
          if (src0_valid_i && (!src1_valid_i || r_last_grant)) begin
            r_state      <= ST_BURST0;
            r_last_grant <= 1'b0;
          end else if (src1_valid_i) begin
            r_state      <= ST_BURST1;
            r_last_grant <= 1'b1;
          end
        end
        ST_BURST0, ST_BURST1: begin
          // Grant is held until BURST_LEN pixels are taken, however long
          // the granted source stays idle.
          if (w_accept) begin
            if (r_beat == c_LAST_BEAT) begin
              r_beat  <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_beat <= r_beat + c_CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  gray_scale_core u_core (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .px_rdy_i  (w_accept),
    .px_i      (w_px),
    .px_rdy_o  (w_core_rdy),
    .px_gray_o (w_core_gray)
  );

  gray_out_fifo #(
    .WIDTH (PIXEL_WIDTH_OUT + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .i_nreset (nreset_i),
    .i_push   (w_core_rdy),
    .i_data   ({r_tag, w_core_gray}),
    .i_pop    (out_valid_o && out_ready_i),
    .o_valid  (w_fifo_valid),
    .o_data   (w_fifo_head),
    .o_count  (w_fifo_count)
  );

  // Everything is gated with nreset_i so outputs read 0 in the reset cycle,
  // and data is zeroed whenever the head is not valid.
  assign src0_ready_o  = w_ready0;
  assign src1_ready_o  = w_ready1;
  assign out_valid_o   = nreset_i && w_fifo_valid;
  assign out_px_gray_o = out_valid_o ? w_fifo_head[PIXEL_WIDTH_OUT-1:0] : '0;
  assign out_src_o     = out_valid_o && w_fifo_head[PIXEL_WIDTH_OUT];
  assign busy_o        = nreset_i &&
                         ((r_state != ST_IDLE) || w_core_rdy || (w_fifo_count != '0));

endmodule
`default_nettype wire
